// File: rtl/sdram_slot_tick.sv
// rtl/sdram_slot_tick.sv - clkref rising-edge detector marking the start of each controller slot
//
// Ports:
//   clk       in   system clock
//   resetn    in   asynchronous active-low reset
//   clkref    in   slot reference from the SDRAM controller, one rising edge per slot
//   slot_tick out  high for the single clk cycle in which clkref is seen rising

module sdram_slot_tick (
  input  logic clk,
  input  logic resetn,
  input  logic clkref,
  output logic slot_tick
);

  logic clkref_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clkref_q <= 1'b0;
    end else begin
      clkref_q <= clkref;
    end
  end

  // A clkref already high when reset releases counts as a fresh slot start.
  assign slot_tick = clkref & ~clkref_q;

endmodule

// File: rtl/sdram_cpu_bridge.sv
// rtl/sdram_cpu_bridge.sv - PicoRV32 32-bit memory port to slot-based 16-bit SDRAM controller bridge
//
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   clkref              controller slot reference (one rising edge per slot)
//   mem_valid/ready     CPU handshake; mem_ready is a one-cycle completion pulse
//   mem_addr/wdata/wstrb/rdata  CPU request fields and read data (addr[24:2] used)
//   sdram_init          controller init request, high until the first slot after reset
//   sdram_addr/we/oe/dqm/din    slot request to the controller, stable for a whole slot
//   sdram_dout          controller read data, sampled at the end of a read slot

module sdram_cpu_bridge #(
  parameter int INIT_SLOTS     = 32,
  parameter int MIN_IDLE_SLOTS = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clkref,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        sdram_init,
  output logic [24:0] sdram_addr,
  output logic        sdram_we,
  output logic        sdram_oe,
  output logic [1:0]  sdram_dqm,
  output logic [15:0] sdram_din,
  input  logic [15:0] sdram_dout
);

  localparam int IW = (INIT_SLOTS > 1) ? $clog2(INIT_SLOTS + 1) : 1;
  localparam int GW = (MIN_IDLE_SLOTS > 1) ? $clog2(MIN_IDLE_SLOTS + 1) : 1;
  localparam logic [IW-1:0] INIT_LOAD = IW'(INIT_SLOTS);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(MIN_IDLE_SLOTS);

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_LO   = 3'd2;
  localparam logic [2:0] S_HI   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;

  logic          slot_tick;
  logic [2:0]    state, state_n;
  logic [IW-1:0] init_cnt, init_cnt_n;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic          init_n, ready_n;
  logic          accept, drive_half, drive_hi, drive_idle, cap_lo, cap_hi;

  logic [22:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   rdata_q;
  logic          is_read;

  logic [22:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [3:0]    sel_wstrb;

  logic [24:0]   nx_addr;
  logic          nx_we, nx_oe;
  logic [1:0]    nx_dqm;
  logic [15:0]   nx_din;

  logic          unused_addr_bits;
  assign unused_addr_bits = &{1'b0, mem_addr[31:25], mem_addr[1:0]};

  sdram_slot_tick u_slot_tick (
    .clk       (clk),
    .resetn    (resetn),
    .clkref    (clkref),
    .slot_tick (slot_tick)
  );

  assign is_read   = (wstrb_q == 4'b0000);
  assign mem_rdata = rdata_q;

  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    gap_cnt_n  = gap_cnt;
    init_n     = sdram_init;
    ready_n    = 1'b0;
    accept     = 1'b0;
    drive_half = 1'b0;
    drive_hi   = 1'b0;
    drive_idle = 1'b0;
    cap_lo     = 1'b0;
    cap_hi     = 1'b0;

    case (state)
      S_INIT: begin
        if (slot_tick) begin
          init_n = 1'b0;
          if (init_cnt <= IW'(1)) begin
            init_cnt_n = '0;
            state_n    = S_IDLE;
          end else begin
            init_cnt_n = init_cnt - IW'(1);
          end
        end
      end
      S_IDLE: begin
        if (slot_tick && mem_valid) accept = 1'b1;
      end
      S_LO: begin
        if (slot_tick) begin
          cap_lo = is_read;
          if (is_read || (wstrb_q[3:2] != 2'b00)) begin
            drive_half = 1'b1;
            drive_hi   = 1'b1;
            state_n    = S_HI;
          end else begin
            drive_idle = 1'b1;
            state_n    = S_DONE;
          end
        end
      end
      S_HI: begin
        if (slot_tick) begin
          cap_hi     = is_read;
          drive_idle = 1'b1;
          state_n    = S_DONE;
        end
      end
      S_DONE: begin
        ready_n   = 1'b1;
        gap_cnt_n = GAP_LOAD;
        state_n   = (MIN_IDLE_SLOTS == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        // The idle slot driven at the end of the transfer is the first gap
        // slot, so the last count lets this same tick accept the next request.
        if (slot_tick) begin
          if (gap_cnt <= GW'(1)) begin
            gap_cnt_n = '0;
            if (mem_valid) accept = 1'b1;
            else           state_n = S_IDLE;
          end else begin
            gap_cnt_n = gap_cnt - GW'(1);
          end
        end
      end
      default: state_n = S_INIT;
    endcase

    if (accept) begin
      drive_half = 1'b1;
      if ((mem_wstrb != 4'b0000) && (mem_wstrb[1:0] == 2'b00)) begin
        drive_hi = 1'b1;
        state_n  = S_HI;
      end else begin
        state_n  = S_LO;
      end
    end
  end

  // The accepting edge drives the first half before the fields are latched.
  always_comb begin
    sel_addr  = accept ? mem_addr[24:2] : addr_q;
    sel_wdata = accept ? mem_wdata      : wdata_q;
    sel_wstrb = accept ? mem_wstrb      : wstrb_q;
  end

  always_comb begin
    nx_addr = sdram_addr;
    nx_we   = sdram_we;
    nx_oe   = sdram_oe;
    nx_dqm  = sdram_dqm;
    nx_din  = sdram_din;
    if (drive_half) begin
      nx_addr = {sel_addr, drive_hi, 1'b0};
      if (sel_wstrb == 4'b0000) begin
        nx_we  = 1'b0;
        nx_oe  = 1'b1;
        nx_dqm = 2'b00;
        nx_din = 16'h0000;
      end else begin
        nx_we  = 1'b1;
        nx_oe  = 1'b0;
        nx_dqm = drive_hi ? sel_wstrb[3:2]  : sel_wstrb[1:0];
        nx_din = drive_hi ? sel_wdata[31:16] : sel_wdata[15:0];
      end
    end else if (drive_idle) begin
      nx_we  = 1'b0;
      nx_oe  = 1'b0;
      nx_dqm = 2'b00;
      nx_din = 16'h0000;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_INIT;
      init_cnt   <= INIT_LOAD;
      gap_cnt    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      mem_ready  <= 1'b0;
      sdram_init <= 1'b1;
      sdram_addr <= '0;
      sdram_we   <= 1'b0;
      sdram_oe   <= 1'b0;
      sdram_dqm  <= 2'b00;
      sdram_din  <= 16'h0000;
    end else begin
      state      <= state_n;
      init_cnt   <= init_cnt_n;
      gap_cnt    <= gap_cnt_n;
      mem_ready  <= ready_n;
      sdram_init <= init_n;
      sdram_addr <= nx_addr;
      sdram_we   <= nx_we;
      sdram_oe   <= nx_oe;
      sdram_dqm  <= nx_dqm;
      sdram_din  <= nx_din;
      if (accept) begin
        addr_q  <= mem_addr[24:2];
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
      end
      if (cap_lo) rdata_q[15:0]  <= sdram_dout;
      if (cap_hi) rdata_q[31:16] <= sdram_dout;
    end
  end

endmodule

// File: tb/tb_sdram_cpu_bridge.sv
// tb/tb_sdram_cpu_bridge.sv - directed scoreboard bench for sdram_cpu_bridge

module tb_sdram_cpu_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        clkref = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        sdram_init;
  logic [24:0] sdram_addr;
  logic        sdram_we;
  logic        sdram_oe;
  logic [1:0]  sdram_dqm;
  logic [15:0] sdram_din;
  logic [15:0] sdram_dout;

  typedef struct {
    logic [24:0] addr;
    logic        we;
    logic        oe;
    logic [1:0]  dqm;
    logic [15:0] din;
  } slot_t;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
  } rsp_t;

  slot_t slot_q[$];
  rsp_t  rsp_q[$];

  int     errors = 0;
  int     checks = 0;
  int     tick_cnt = 0;
  int     ready_seen = 0;
  int     ref_phase = 15;
  longint cyc = 0;
  logic   ref_q = 1'b0;
  logic   tick_now = 1'b0;
  logic   ready_prev = 1'b0;
  logic [24:0] snap_addr = '0;
  logic [20:0] snap_ctl = '0;

  sdram_cpu_bridge #(.INIT_SLOTS(32), .MIN_IDLE_SLOTS(1)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .clkref     (clkref),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .sdram_init (sdram_init),
    .sdram_addr (sdram_addr),
    .sdram_we   (sdram_we),
    .sdram_oe   (sdram_oe),
    .sdram_dqm  (sdram_dqm),
    .sdram_din  (sdram_din),
    .sdram_dout (sdram_dout)
  );

  initial forever #5 clk = ~clk;

  // clkref: period 16 clk, high for 8
  always @(negedge clk) begin
    ref_phase = (ref_phase + 1) % 16;
    clkref = (ref_phase < 8);
  end

  function automatic logic [15:0] model_dout(input logic [24:0] a);
    if (a == 25'h0001004) return 16'hBEEF;
    if (a == 25'h0001006) return 16'hDEAD;
    return a[15:0] ^ 16'hA5A5;
  endfunction

  assign sdram_dout = model_dout(sdram_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Slot monitor: active slots against the scoreboard, outputs frozen between ticks
  always @(posedge clk) begin
    tick_now = clkref & ~ref_q;
    ref_q = resetn ? clkref : 1'b0;
    cyc++;
    #1;
    if (!resetn) begin
      tick_cnt = 0;
    end else if (tick_now) begin
      tick_cnt++;
      if (tick_cnt == 1) chk("init_low_after_first_tick", sdram_init, 0);
      if (sdram_we || sdram_oe) begin
        chk("slot_expected", 32'(slot_q.size() != 0), 1);
        if (slot_q.size() != 0) begin
          slot_t e;
          e = slot_q.pop_front();
          chk("slot_addr", sdram_addr, e.addr);
          chk("slot_we", sdram_we, e.we);
          chk("slot_oe", sdram_oe, e.oe);
          chk("slot_dqm", sdram_dqm, e.dqm);
          if (e.we) chk("slot_din", sdram_din, e.din);
        end
      end
    end else begin
      chk("stable_addr", sdram_addr, snap_addr);
      chk("stable_ctl", {sdram_din, sdram_dqm, sdram_we, sdram_oe, sdram_init}, snap_ctl);
    end
    snap_addr = sdram_addr;
    snap_ctl = {sdram_din, sdram_dqm, sdram_we, sdram_oe, sdram_init};
  end

  // Completion monitor
  always @(negedge clk) begin
    if (resetn && mem_ready === 1'b1) begin
      ready_seen++;
      chk("ready_one_cycle", ready_prev, 0);
      chk("ready_expected", 32'(rsp_q.size() != 0), 1);
      if (rsp_q.size() != 0) begin
        rsp_t r;
        r = rsp_q.pop_front();
        if (r.is_read) chk("rdata", mem_rdata, r.data);
      end
    end
    ready_prev = mem_ready;
  end

  task automatic start_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    slot_t s;
    rsp_t r;
    logic [24:0] base;
    base = {a[24:2], 2'b00};
    r.is_read = (ws == 4'b0000);
    r.data = '0;
    if (ws == 4'b0000) begin
      s.addr = base; s.we = 1'b0; s.oe = 1'b1; s.dqm = 2'b00; s.din = '0;
      slot_q.push_back(s);
      s.addr = base | 25'd2;
      slot_q.push_back(s);
      r.data = {model_dout(base | 25'd2), model_dout(base)};
    end else begin
      if (ws[1:0] != 2'b00) begin
        s.addr = base; s.we = 1'b1; s.oe = 1'b0; s.dqm = ws[1:0]; s.din = wd[15:0];
        slot_q.push_back(s);
      end
      if (ws[3:2] != 2'b00) begin
        s.addr = base | 25'd2; s.we = 1'b1; s.oe = 1'b0; s.dqm = ws[3:2]; s.din = wd[31:16];
        slot_q.push_back(s);
      end
    end
    rsp_q.push_back(r);
    mem_addr = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    mem_valid = 1'b1;
  endtask

  task automatic wait_done(input bit hold, input bit scramble, input bit drop,
                           output int lat, output int acc_tick, output longint acc_cyc);
    bit acc;
    bit done;
    int n;
    acc = 0; done = 0; n = 0;
    lat = -1; acc_tick = -1; acc_cyc = -1;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (acc) n++;
      if (!acc && (sdram_we || sdram_oe)) begin
        acc = 1; n = 0; acc_tick = tick_cnt; acc_cyc = cyc;
        if (scramble) begin
          mem_addr = 32'h01FF_FFFC; mem_wdata = 32'h5A5A_5A5A; mem_wstrb = 4'b0001;
        end
        if (drop) mem_valid = 1'b0;
      end
      if (mem_ready === 1'b1) begin
        done = 1; lat = n;
        if (!hold) mem_valid = 1'b0;
      end
    end
    chk("xfer_completed", 32'(done), 1);
  endtask

  task automatic release_reset();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (ref_phase == 10) break;
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, at, at0, rs;
    longint ac1, ac2;
    bit found;

    repeat (3) @(negedge clk);
    chk("rst_init", sdram_init, 1);
    chk("rst_we", sdram_we, 0);
    chk("rst_oe", sdram_oe, 0);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_dqm", sdram_dqm, 0);
    chk("rst_din", sdram_din, 0);
    chk("rst_ready", mem_ready, 0);
    chk("rst_rdata", mem_rdata, 0);

    release_reset();
    start_req(32'h0000_1004, 32'h0, 4'b0000);
    #1 chk("init_before_first_tick", sdram_init, 1);
    wait_done(0, 0, 0, lat, at, ac1);
    chk("init_accept_tick", at, 33);
    chk("read_latency", lat, 33);

    start_req(32'h0000_2000, 32'h1122_3344, 4'b1111);
    wait_done(1, 1, 0, lat, at, ac1);
    chk("full_write_latency", lat, 33);
    start_req(32'h0000_2008, 32'h0, 4'b0000);
    wait_done(0, 0, 0, lat, at, ac2);
    chk("write_gap_accept_spacing", 32'(ac2 - ac1), 48);
    chk("read_after_write_latency", lat, 33);

    start_req(32'h0000_3000, 32'h1122_3344, 4'b1000);
    wait_done(0, 0, 0, lat, at, ac1);
    chk("half_write_hi_latency", lat, 17);

    start_req(32'h0000_5000, 32'hCAFE_F00D, 4'b0011);
    wait_done(0, 0, 0, lat, at, ac1);
    chk("half_write_lo_latency", lat, 17);

    start_req(32'h0000_6000, 32'h0, 4'b0000);
    wait_done(1, 0, 0, lat, at, ac1);
    chk("b2b_read1_latency", lat, 33);
    start_req(32'h0000_7004, 32'h0, 4'b0000);
    wait_done(0, 0, 0, lat, at, ac2);
    chk("b2b_read_spacing", 32'(ac2 - ac1), 48);
    chk("b2b_read2_latency", lat, 33);

    start_req(32'h0000_8000, 32'h0, 4'b0000);
    wait_done(0, 0, 1, lat, at, ac1);
    chk("dropped_valid_latency", lat, 33);

    repeat (64) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (ref_phase == 15) break;
    end
    @(negedge clk);
    at0 = tick_cnt;
    start_req(32'h0000_9000, 32'h0, 4'b0000);
    wait_done(0, 0, 0, lat, at, ac1);
    chk("same_edge_accept_tick", at, at0 + 1);
    chk("same_edge_latency", lat, 33);

    start_req(32'h0000_4000, 32'hA1B2_C3D4, 4'b1111);
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (sdram_we && sdram_addr == 25'h0004002) found = 1;
    end
    chk("abort_hi_slot_reached", 32'(found), 1);
    repeat (3) @(negedge clk);
    rs = ready_seen;
    resetn = 1'b0;
    mem_valid = 1'b0;
    #1;
    chk("abort_init", sdram_init, 1);
    chk("abort_we", sdram_we, 0);
    chk("abort_oe", sdram_oe, 0);
    chk("abort_addr", sdram_addr, 0);
    chk("abort_dqm", sdram_dqm, 0);
    chk("abort_din", sdram_din, 0);
    chk("abort_ready", mem_ready, 0);
    slot_q.delete();
    rsp_q.delete();
    repeat (5) @(negedge clk);
    release_reset();
    repeat (64) @(negedge clk);
    chk("abort_no_ready", ready_seen, rs);

    start_req(32'h0000_1004, 32'h0, 4'b0000);
    wait_done(0, 0, 0, lat, at, ac1);
    chk("reinit_accept_tick", at, 33);
    chk("reinit_read_latency", lat, 33);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_cpu_bridge.md
Name: sdram_cpu_bridge

Overview:
- Upstream stage of the picosoc SDRAM controller.
- Converts the PicoRV32 native memory interface (32-bit, mem_valid/mem_ready) into the controller's 16-bit, slot-based request interface.
- The controller runs one access per 16-clk slot, aligned to clkref. This bridge therefore:
  - splits each word into two half-word slots;
  - holds each request stable for a full slot;
  - captures read data at slot end;
  - guarantees idle (auto-refresh) slots and waits out controller initialisation.

Parameters:
INIT_SLOTS, 32, slots to hold off after reset while the controller runs its init sequence (must be ≥ controller reset count + 1)
MIN_IDLE_SLOTS, 1, idle slots forced after each completed CPU transfer (controller refreshes on idle slots); 0 allowed

Ports:
clk  in  1  system/SDRAM state-machine clock
resetn  in  1  asynchronous active-low reset
clkref  in  1  slot reference, same as the controller's clkref; one rising edge per slot
mem_valid  in  1  CPU request valid; held until mem_ready
mem_ready  out  1  one-cycle completion pulse
mem_addr  in  32  CPU byte address; [24:2] used, others ignored (decoded upstream)
mem_wdata  in  32  write data
mem_wstrb  in  4  byte write strobes; 0 = read
mem_rdata  out  32  read data, valid while mem_ready=1
sdram_init  out  1  controller init request
sdram_addr  out  25  byte address to controller
sdram_we  out  1  write request
sdram_oe  out  1  read request
sdram_dqm  out  2  active-high byte enables for writes
sdram_din  out  16  write half-word
sdram_dout  in  16  controller read data (its registered doutA)

Behaviour:
- Reset values (asynchronous on resetn=0):
  - sdram_init=1; all other outputs 0.
  - state=INIT, init_cnt=INIT_SLOTS.
- Slot tick:
  - clkref_q<=clkref every cycle.
  - slot_tick = clkref & ~clkref_q.
  - All SDRAM-side outputs change only on the clk edge where slot_tick=1, so each request is stable for the whole controller slot.
- INIT:
  - sdram_init drops to 0 on the first slot_tick.
  - init_cnt decrements on each slot_tick.
  - At 0 → IDLE.
  - mem_valid is ignored in this state (mem_ready stays 0).
- IDLE:
  - Outputs we=oe=0, which gives a controller refresh slot.
  - On slot_tick with mem_valid=1, latch addr/wdata/wstrb, then:
    - read (wstrb==0) → LO;
    - write with wstrb[1:0]!=0 → LO;
    - write with wstrb[1:0]==0 → HI (low half skipped).
  - Drive the chosen half on that same edge.
- Half drive, for h∈{0,1}:
  - sdram_addr={addr[24:2],h,1'b0}.
  - Read: oe=1, we=0, dqm=2'b00.
  - Write: we=1, oe=0, din=wdata[16h+15:16h], dqm=wstrb[2h+1:2h].
- LO, on slot_tick:
  - If read, rdata[15:0]<=sdram_dout.
  - Next half is needed if read or wstrb[3:2]!=0: drive high half → HI.
  - Otherwise drive idle → DONE.
- HI, on slot_tick:
  - If read, rdata[31:16]<=sdram_dout.
  - Drive idle → DONE.
- DONE:
  - mem_ready=1 for exactly one cycle; mem_rdata holds the assembled word (writes: value unspecified).
  - gap_cnt<=MIN_IDLE_SLOTS.
  - → GAP, or → IDLE if MIN_IDLE_SLOTS=0.
- GAP:
  - Decrement gap_cnt on slot_tick; at 0 → IDLE.
  - The next request is accepted on the following slot_tick at the earliest.
- Latency, measured in slots from acceptance to mem_ready:
  - read or full write: 2 slots + 1 clk;
  - half-word write: 1 slot + 1 clk.
  - Add up to 1 slot of alignment wait before acceptance.
- Boundary conditions:
  - mem_valid dropping mid-transfer is illegal (PicoRV32 never does it); the transfer completes anyway.
  - mem_valid rising on the same edge as slot_tick is accepted.
  - Request fields are latched, so CPU changes after acceptance have no effect.
  - Asynchronous reset mid-transfer aborts the transfer and returns to INIT (controller re-initialised).
  - No clkref edges means the bridge stalls; there is no timeout.

Decomposition:
- No package. State encodings (INIT/IDLE/LO/HI/DONE/GAP) are localparams.
- One natural sub-module: sdram_slot_tick (clkref edge detector, async-reset flop). It is reusable by other controller clients.

Test Plan:
All scenarios use a clkref period of 16 clk, high for 8, and a simple controller model returning sdram_dout per half-address.
- Reset release → sdram_init high until the first tick; a mem_valid read issued early gets no mem_ready until 32 slots have elapsed.
- Read 0x0000_1004 with model data lo=0xBEEF, hi=0xDEAD:
  - sdram_addr=0x1004 then 0x1006, oe=1, we=0;
  - mem_rdata=0xDEADBEEF with mem_ready, 2 slots + 1 clk after acceptance.
- Write 0x0000_2000, wdata=0x11223344, wstrb=4'b1111:
  - two write slots, din 0x3344/dqm 2'b11 then 0x1122/2'b11;
  - one idle slot (we=oe=0) before the next accept.
- Write wstrb=4'b1000 at 0x0000_3000:
  - single slot, sdram_addr=0x3002, din=0x1122, dqm=2'b10;
  - mem_ready 1 slot + 1 clk after acceptance.
- Back-to-back reads with mem_valid held continuously:
  - accept only after the GAP slot;
  - throughput is one read per 3 slots with MIN_IDLE_SLOTS=1.
- Assert resetn=0 during the HI slot of a write:
  - all outputs 0 and sdram_init=1 immediately;
  - no mem_ready for the aborted transfer.
